// File: rtl/id_ex_pkg.sv
// Shared constants and decode bundle for the ID/EX stage.
package id_ex_pkg;

   localparam int W_DEF  = 32;
   localparam int RW_DEF = 5;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   typedef enum logic [1:0] {
      WB_NONE = 2'd0,
      WB_RD   = 2'd1,
      WB_RT   = 2'd2
   } wb_sel_e;

   typedef struct packed {
      logic [2:0] alu_op;
      logic       use_imm;
      wb_sel_e    wb_sel;
      logic       reg_we;
      logic       mem_rd;
      logic       mem_wr;
      logic       is_branch;
      logic       illegal;
   } dec_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side and execute-side bundles of the ID/EX stage.
interface id_ex_dec_if
   import id_ex_pkg::*;
#(
   parameter int W  = W_DEF,
   parameter int RW = RW_DEF
);
   logic          in_valid;
   logic          in_ready;
   logic [5:0]    opcode;
   logic [5:0]    funct;
   logic [RW-1:0] rs_idx;
   logic [RW-1:0] rt_idx;
   logic [RW-1:0] rd_idx;
   logic [W-1:0]  rd1;
   logic [W-1:0]  rd2;
   logic [15:0]   imm;
   logic          flush;
   logic          exmem_we;
   logic [RW-1:0] exmem_rd;
   logic [W-1:0]  exmem_z;
   logic          memwb_we;
   logic [RW-1:0] memwb_rd;
   logic [W-1:0]  memwb_z;

   modport master (
      output in_valid, opcode, funct,
      output rs_idx, rt_idx, rd_idx,
      output rd1, rd2, imm, flush,
      output exmem_we, exmem_rd, exmem_z,
      output memwb_we, memwb_rd, memwb_z,
      input  in_ready
   );

   modport slave (
      input  in_valid, opcode, funct,
      input  rs_idx, rt_idx, rd_idx,
      input  rd1, rd2, imm, flush,
      input  exmem_we, exmem_rd, exmem_z,
      input  memwb_we, memwb_rd, memwb_z,
      output in_ready
   );
endinterface

interface id_ex_ex_if
   import id_ex_pkg::*;
#(
   parameter int W  = W_DEF,
   parameter int RW = RW_DEF
);
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  alu_a;
   logic [W-1:0]  alu_b;
   logic [2:0]    alu_op;
   logic [W-1:0]  st_data;
   logic [RW-1:0] wb_rd;
   logic          reg_we;
   logic          mem_rd;
   logic          mem_wr;
   logic          is_branch;
   logic          illegal;

   modport master (
      output out_valid, alu_a, alu_b, alu_op,
      output st_data, wb_rd, reg_we,
      output mem_rd, mem_wr, is_branch, illegal,
      input  out_ready
   );

   modport slave (
      input  out_valid, alu_a, alu_b, alu_op,
      input  st_data, wb_rd, reg_we,
      input  mem_rd, mem_wr, is_branch, illegal,
      output out_ready
   );
endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand bypass select: EX/MEM beats MEM/WB, index 0 never bypassed.
module fwd_mux
   import id_ex_pkg::*;
#(
   parameter int W  = W_DEF,
   parameter int RW = RW_DEF
) (
   input  logic [RW-1:0] idx,
   input  logic [W-1:0]  regval,
   input  logic          exmem_we,
   input  logic [RW-1:0] exmem_rd,
   input  logic [W-1:0]  exmem_z,
   input  logic          memwb_we,
   input  logic [RW-1:0] memwb_rd,
   input  logic [W-1:0]  memwb_z,
   output logic [W-1:0]  value
);

   logic nz;
   logic ex_hit;
   logic wb_hit;

   assign nz     = (idx != '0);
   assign ex_hit = exmem_we && (exmem_rd == idx) && nz;
   assign wb_hit = memwb_we && (memwb_rd == idx) && nz;

   always_comb begin
      value = regval;
      if (ex_hit)
         value = exmem_z;
      else if (wb_hit)
         value = memwb_z;
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand resolution and decode.
// Bypassing is enabled by defining ID_EX_FWD_EN.
module id_ex_stage
   import id_ex_pkg::*;
#(
   parameter int W  = W_DEF,
   parameter int RW = RW_DEF
) (
   input  logic       clk,
   input  logic       reset,
   id_ex_dec_if.slave dec,
   id_ex_ex_if.master ex
);

   logic [W-1:0] a_val;
   logic [W-1:0] b_reg;

`ifdef ID_EX_FWD_EN
   fwd_mux #(.W(W), .RW(RW)) u_fwd_a (
      .idx      (dec.rs_idx),
      .regval   (dec.rd1),
      .exmem_we (dec.exmem_we),
      .exmem_rd (dec.exmem_rd),
      .exmem_z  (dec.exmem_z),
      .memwb_we (dec.memwb_we),
      .memwb_rd (dec.memwb_rd),
      .memwb_z  (dec.memwb_z),
      .value    (a_val)
   );

   fwd_mux #(.W(W), .RW(RW)) u_fwd_b (
      .idx      (dec.rt_idx),
      .regval   (dec.rd2),
      .exmem_we (dec.exmem_we),
      .exmem_rd (dec.exmem_rd),
      .exmem_z  (dec.exmem_z),
      .memwb_we (dec.memwb_we),
      .memwb_rd (dec.memwb_rd),
      .memwb_z  (dec.memwb_z),
      .value    (b_reg)
   );
`else
   // Hazard unit stalls instead; bypass inputs are ignored.
   assign a_val = dec.rd1;
   assign b_reg = dec.rd2;

   logic unused_fwd;
   assign unused_fwd = ^{dec.exmem_we, dec.exmem_rd,
                         dec.exmem_z, dec.memwb_we,
                         dec.memwb_rd, dec.memwb_z};
`endif

   logic is_r, is_addi, is_lw;
   logic is_sw, is_beq, is_j;

   assign is_r    = (dec.opcode == OP_RTYPE);
   assign is_addi = (dec.opcode == OP_ADDI);
   assign is_lw   = (dec.opcode == OP_LW);
   assign is_sw   = (dec.opcode == OP_SW);
   assign is_beq  = (dec.opcode == OP_BEQ);
   assign is_j    = (dec.opcode == OP_J);

   logic fn_add, fn_sub, fn_and;
   logic fn_or, fn_slt;

   assign fn_add = (dec.funct == FN_ADD);
   assign fn_sub = (dec.funct == FN_SUB);
   assign fn_and = (dec.funct == FN_AND);
   assign fn_or  = (dec.funct == FN_OR);
   assign fn_slt = (dec.funct == FN_SLT);

   dec_t dc;

   always_comb begin
      dc        = '0;
      dc.alu_op = ALU_ADD;
      dc.wb_sel = WB_NONE;
      unique case (1'b1)
         is_r: begin
            dc.wb_sel = WB_RD;
            dc.reg_we = 1'b1;
            unique case (1'b1)
               fn_add:  dc.alu_op = ALU_ADD;
               fn_sub:  dc.alu_op = ALU_SUB;
               fn_and:  dc.alu_op = ALU_AND;
               fn_or:   dc.alu_op = ALU_OR;
               fn_slt:  dc.alu_op = ALU_SLT;
               default: begin
                  dc.illegal = 1'b1;
                  dc.reg_we  = 1'b0;
                  dc.wb_sel  = WB_NONE;
               end
            endcase
         end
         is_addi: begin
            dc.use_imm = 1'b1;
            dc.wb_sel  = WB_RT;
            dc.reg_we  = 1'b1;
         end
         is_lw: begin
            dc.use_imm = 1'b1;
            dc.wb_sel  = WB_RT;
            dc.reg_we  = 1'b1;
            dc.mem_rd  = 1'b1;
         end
         is_sw: begin
            dc.use_imm = 1'b1;
            dc.mem_wr  = 1'b1;
         end
         is_beq: begin
            dc.alu_op    = ALU_SUB;
            dc.is_branch = 1'b1;
         end
         is_j:    dc.alu_op  = ALU_ADD;
         default: dc.illegal = 1'b1;
      endcase
   end

   logic [W-1:0]  sext;
   logic [W-1:0]  b_val;
   logic [RW-1:0] wb_idx;

   assign sext  = {{(W-16){dec.imm[15]}}, dec.imm};
   assign b_val = dc.use_imm ? sext : b_reg;

   always_comb begin
      wb_idx = '0;
      unique case (dc.wb_sel)
         WB_RD:   wb_idx = dec.rd_idx;
         WB_RT:   wb_idx = dec.rt_idx;
         default: wb_idx = '0;
      endcase
   end

   logic          v_q;
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic [2:0]    op_q;
   logic [W-1:0]  st_q;
   logic [RW-1:0] wb_q;
   logic          we_q, mr_q, mw_q;
   logic          br_q, il_q;

   logic ready;
   logic capture;

   assign ready   = !v_q || ex.out_ready;
   assign capture = dec.in_valid && ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         v_q  <= 1'b0;
         a_q  <= '0;
         b_q  <= '0;
         op_q <= '0;
         st_q <= '0;
         wb_q <= '0;
         we_q <= 1'b0;
         mr_q <= 1'b0;
         mw_q <= 1'b0;
         br_q <= 1'b0;
         il_q <= 1'b0;
      end else if (dec.flush) begin
         v_q <= 1'b0;
      end else if (capture) begin
         v_q  <= 1'b1;
         a_q  <= a_val;
         b_q  <= b_val;
         op_q <= dc.alu_op;
         st_q <= b_reg;
         wb_q <= wb_idx;
         we_q <= dc.reg_we;
         mr_q <= dc.mem_rd;
         mw_q <= dc.mem_wr;
         br_q <= dc.is_branch;
         il_q <= dc.illegal;
      end else if (ex.out_ready) begin
         v_q <= 1'b0;
      end
   end

   assign dec.in_ready = ready;
   assign ex.out_valid = v_q;
   assign ex.alu_a     = a_q;
   assign ex.alu_b     = b_q;
   assign ex.alu_op    = op_q;
   assign ex.st_data   = st_q;
   assign ex.wb_rd     = wb_q;
   assign ex.reg_we    = we_q;
   assign ex.mem_rd    = mr_q;
   assign ex.mem_wr    = mw_q;
   assign ex.is_branch = br_q;
   assign ex.illegal   = il_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed vector bench for id_ex_stage.
module tb_id_ex_stage;
   import id_ex_pkg::*;

`ifdef ID_EX_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   id_ex_dec_if d ();
   id_ex_ex_if  e ();

   id_ex_stage dut (
      .clk   (clk),
      .reset (reset),
      .dec   (d),
      .ex    (e)
   );

   typedef struct {
      logic [5:0]  opcode;
      logic [5:0]  funct;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [15:0] imm;
      logic        xwe;
      logic [4:0]  xrd;
      logic [31:0] xz;
      logic        wwe;
      logic [4:0]  wrd;
      logic [31:0] wz;
      logic [31:0] ea;
      logic [31:0] eb;
      logic [2:0]  eop;
      logic [31:0] est;
      logic [4:0]  ewb;
      logic [4:0]  efl;
   } vec_t;

   localparam int NV = 16;
   vec_t vec [NV];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(vec_t v);
      d.opcode   = v.opcode;
      d.funct    = v.funct;
      d.rs_idx   = v.rs;
      d.rt_idx   = v.rt;
      d.rd_idx   = v.rd;
      d.rd1      = v.rd1;
      d.rd2      = v.rd2;
      d.imm      = v.imm;
      d.exmem_we = v.xwe;
      d.exmem_rd = v.xrd;
      d.exmem_z  = v.xz;
      d.memwb_we = v.wwe;
      d.memwb_rd = v.wrd;
      d.memwb_z  = v.wz;
   endtask

   function automatic logic [31:0] flags();
      return {27'd0, e.reg_we, e.mem_rd, e.mem_wr,
              e.is_branch, e.illegal};
   endfunction

   initial begin
      vec[0]  = '{6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'h0000, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'd5, 32'd7, 3'b010, 32'd7, 5'd3, 5'b10000};
      vec[1]  = '{6'h00, 6'h22, 5'd1, 5'd2, 5'd9, 32'd10, 32'd3, 16'h1234, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'd10, 32'd3, 3'b110, 32'd3, 5'd9, 5'b10000};
      vec[2]  = '{6'h00, 6'h24, 5'd7, 5'd8, 5'd4, 32'hF0F0, 32'h0FF0, 16'h0000, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'hF0F0, 32'h0FF0, 3'b000, 32'h0FF0, 5'd4, 5'b10000};
      vec[3]  = '{6'h00, 6'h25, 5'd7, 5'd8, 5'd5, 32'hF0F0, 32'h0FF0, 16'h0000, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'hF0F0, 32'h0FF0, 3'b001, 32'h0FF0, 5'd5, 5'b10000};
      vec[4]  = '{6'h00, 6'h2A, 5'd7, 5'd8, 5'd6, 32'h1, 32'h2, 16'h0000, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h1, 32'h2, 3'b111, 32'h2, 5'd6, 5'b10000};
      vec[5]  = '{6'h23, 6'h00, 5'd1, 5'd6, 5'd0, 32'h100, 32'h55, 16'hFFFC, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h100, 32'hFFFFFFFC, 3'b010, 32'h55, 5'd6, 5'b11000};
      vec[6]  = '{6'h08, 6'h00, 5'd2, 5'd7, 5'd0, 32'h20, 32'h9, 16'h0010, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h20, 32'h10, 3'b010, 32'h9, 5'd7, 5'b10000};
      vec[7]  = '{6'h2B, 6'h00, 5'd3, 5'd4, 5'd0, 32'h40, 32'hDEAD, 16'h8000, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h40, 32'hFFFF8000, 3'b010, 32'hDEAD, 5'd0, 5'b00100};
      vec[8]  = '{6'h04, 6'h00, 5'd1, 5'd2, 5'd0, 32'd5, 32'd5, 16'h0003, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'd5, 32'd5, 3'b110, 32'd5, 5'd0, 5'b00010};
      vec[9]  = '{6'h02, 6'h00, 5'd0, 5'd0, 5'd0, 32'h11, 32'h0, 16'h0000, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h11, 32'h0, 3'b010, 32'h0, 5'd0, 5'b00000};
      vec[10] = '{6'h3F, 6'h00, 5'd1, 5'd2, 5'd3, 32'h1, 32'h0, 16'h0000, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h1, 32'h0, 3'b010, 32'h0, 5'd0, 5'b00001};
      vec[11] = '{6'h00, 6'h21, 5'd1, 5'd2, 5'd3, 32'h1, 32'h0, 16'h0000, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h1, 32'h0, 3'b010, 32'h0, 5'd0, 5'b00001};
      vec[12] = '{6'h00, 6'h20, 5'd4, 5'd2, 5'd3, 32'h11, 32'h22, 16'h0000, 1'b1, 5'd4, 32'hAA, 1'b1, 5'd4, 32'hBB, FWD ? 32'hAA : 32'h11, 32'h22, 3'b010, 32'h22, 5'd3, 5'b10000};
      vec[13] = '{6'h00, 6'h20, 5'd0, 5'd0, 5'd3, 32'h11, 32'h22, 16'h0000, 1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB, 32'h11, 32'h22, 3'b010, 32'h22, 5'd3, 5'b10000};
      vec[14] = '{6'h00, 6'h20, 5'd1, 5'd5, 5'd6, 32'h1, 32'h22, 16'h0000, 1'b0, 5'd5, 32'hAA, 1'b1, 5'd5, 32'hCC, 32'h1, FWD ? 32'hCC : 32'h22, 3'b010, FWD ? 32'hCC : 32'h22, 5'd6, 5'b10000};
      vec[15] = '{6'h2B, 6'h00, 5'd1, 5'd9, 5'd0, 32'h200, 32'h33, 16'h0004, 1'b1, 5'd9, 32'h77, 1'b1, 5'd9, 32'h88, 32'h200, 32'h4, 3'b010, FWD ? 32'h77 : 32'h33, 5'd0, 5'b00100};

      reset       = 1'b1;
      d.in_valid  = 1'b0;
      d.flush     = 1'b0;
      e.out_ready = 1'b1;
      drive(vec[0]);
      tick();
      tick();
      reset = 1'b0;
      tick();
      chk("reset out_valid", {31'd0, e.out_valid}, 32'd0);
      chk("reset in_ready", {31'd0, d.in_ready}, 32'd1);
      chk("reset alu_a", e.alu_a, 32'd0);
      chk("reset alu_b", e.alu_b, 32'd0);
      chk("reset alu_op", {29'd0, e.alu_op}, 32'd0);
      chk("reset st_data", e.st_data, 32'd0);
      chk("reset wb_rd", {27'd0, e.wb_rd}, 32'd0);
      chk("reset flags", flags(), 32'd0);

      for (int i = 0; i < NV; i++) begin
         drive(vec[i]);
         d.in_valid = 1'b1;
         tick();
         chk($sformatf("v%0d out_valid", i), {31'd0, e.out_valid}, 32'd1);
         chk($sformatf("v%0d alu_a", i), e.alu_a, vec[i].ea);
         chk($sformatf("v%0d alu_b", i), e.alu_b, vec[i].eb);
         chk($sformatf("v%0d alu_op", i), {29'd0, e.alu_op}, {29'd0, vec[i].eop});
         chk($sformatf("v%0d st_data", i), e.st_data, vec[i].est);
         chk($sformatf("v%0d flags", i), flags(), {27'd0, vec[i].efl});
         if (vec[i].efl[4])
            chk($sformatf("v%0d wb_rd", i), {27'd0, e.wb_rd}, {27'd0, vec[i].ewb});
      end

      // stall: hold vec0 while vec6 waits for three cycles
      drive(vec[0]);
      tick();
      drive(vec[6]);
      e.out_ready = 1'b0;
      #1;
      chk("stall in_ready", {31'd0, d.in_ready}, 32'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("stall%0d out_valid", k), {31'd0, e.out_valid}, 32'd1);
         chk($sformatf("stall%0d alu_a", k), e.alu_a, 32'd5);
         chk($sformatf("stall%0d alu_b", k), e.alu_b, 32'd7);
         chk($sformatf("stall%0d in_ready", k), {31'd0, d.in_ready}, 32'd0);
      end
      e.out_ready = 1'b1;
      #1;
      chk("release in_ready", {31'd0, d.in_ready}, 32'd1);
      tick();
      chk("release out_valid", {31'd0, e.out_valid}, 32'd1);
      chk("release alu_a", e.alu_a, 32'h20);
      chk("release alu_b", e.alu_b, 32'h10);

      // flush while holding with a new instruction offered
      e.out_ready = 1'b0;
      drive(vec[2]);
      d.flush = 1'b1;
      tick();
      chk("flush out_valid", {31'd0, e.out_valid}, 32'd0);
      d.flush    = 1'b0;
      d.in_valid = 1'b0;
      tick();
      chk("flush no capture", {31'd0, e.out_valid}, 32'd0);
      chk("flush alu_a", e.alu_a, 32'h20);
      chk("flush in_ready", {31'd0, d.in_ready}, 32'd1);

      // drain without a replacement
      e.out_ready = 1'b1;
      drive(vec[0]);
      d.in_valid = 1'b1;
      tick();
      chk("drain fill", {31'd0, e.out_valid}, 32'd1);
      d.in_valid = 1'b0;
      tick();
      chk("drain out_valid", {31'd0, e.out_valid}, 32'd0);

      // reset during a stall drops the held instruction
      drive(vec[5]);
      d.in_valid = 1'b1;
      tick();
      e.out_ready = 1'b0;
      drive(vec[6]);
      reset = 1'b1;
      tick();
      chk("rst stall out_valid", {31'd0, e.out_valid}, 32'd0);
      chk("rst stall alu_b", e.alu_b, 32'd0);
      chk("rst stall flags", flags(), 32'd0);
      reset      = 1'b0;
      d.in_valid = 1'b0;
      tick();
      chk("rst stall idle", {31'd0, e.out_valid}, 32'd0);
      chk("rst stall in_ready", {31'd0, d.in_ready}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Single-entry ID/EX pipeline register feeding the 32-bit ALU in the execute stage.
- Captures decoded register operands, the immediate and destination index.
- Resolves the ALU b operand (register or sign-extended immediate) and the 3-bit ALU op.
- Applies EX/MEM and MEM/WB forwarding at capture; valid/ready handshake on both sides, plus flush.

Parameters:
- W, 32, datapath width (operands, forwarded results)
- RW, 5, register index width

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  decode stage presents an instruction
- in_ready  out  1  stage can accept this cycle
- opcode  in  6  instr[31:26]
- funct  in  6  instr[5:0]
- rs_idx, rt_idx, rd_idx  in  RW each  instr[25:21], [20:16], [15:11]
- rd1, rd2  in  W each  register file read data for rs, rt
- imm  in  16  instr[15:0]
- flush  in  1  kill held and incoming instruction
- exmem_we, memwb_we  in  1 each  forwarding source write enables
- exmem_rd, memwb_rd  in  RW each  forwarding destination indices
- exmem_z, memwb_z  in  W each  forwarding data
- out_valid  out  1  ALU operands valid
- out_ready  in  1  execute stage consumes
- alu_a, alu_b  out  W each  ALU operands
- alu_op  out  3  000 and, 001 or, 010 add, 110 sub, 111 slt
- st_data  out  W  forwarded rt value, for sw
- wb_rd  out  RW  writeback index (rd for R-type, rt for addi/lw)
- reg_we, mem_rd, mem_wr, is_branch, illegal  out  1 each

Behaviour:
- Reset: out_valid=0; all data/control outputs 0; in_ready=1 from the first cycle after reset.
- in_ready = !out_valid || out_ready (combinational).
- Capture when in_valid && in_ready && !flush. Outputs are valid the next cycle: 1-cycle latency.
- Held contents stay stable while out_valid && !out_ready.
- Next-state priority: reset > flush > capture > drain.
  - flush: out_valid=0 next cycle; incoming instruction dropped.
  - Drain (out_ready && !capture): out_valid=0.
  - Capture and drain in the same cycle: replace contents, out_valid stays 1.
- Forwarding, computed per source (rs, rt) before capture:
  - EX/MEM match: exmem_we && exmem_rd==idx && idx!=0.
  - MEM/WB match: same test on memwb_*.
  - EX/MEM wins over MEM/WB. Index 0 is never forwarded.
- Decode:
  - R-type (opcode 0x00): funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt. b=rt, wb_rd=rd_idx, reg_we=1.
  - addi 0x08: add, b=sext(imm), wb_rd=rt, reg_we=1.
  - lw 0x23: add, b=sext(imm), mem_rd=1, reg_we=1, wb_rd=rt.
  - sw 0x2B: add, b=sext(imm), mem_wr=1, st_data=fwd rt.
  - beq 0x04: sub, b=rt, is_branch=1.
  - j 0x02: no writes, alu_op add.
- Any other opcode/funct: illegal=1, reg_we=mem_rd=mem_wr=is_branch=0, alu_op=add.
- Sign extension: imm[15] replicated to W bits.
- Reset mid-stall: stage empties; the held instruction is lost.

Optional Feature:
- Macro: ID_EX_FWD_EN.
- Defined: forwarding as above.
- Undefined: rd1/rd2 captured unmodified. The forwarding ports remain in the interface and are ignored; the hazard unit must stall instead.

Decomposition:
- Package id_ex_pkg:
  - Opcode and funct constants (OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT).
  - ALU op encodings (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT).
  - W and RW defaults.
- Sub-module fwd_mux: one per source operand (idx, regval, exmem_*, memwb_*) -> value. Instantiated twice.
- Decode logic stays inline.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=1, all outputs 0.
- add (funct 0x20), rd1=5, rd2=7, rd_idx=3, out_ready=1 -> next cycle out_valid=1, alu_a=5, alu_b=7, alu_op=010, wb_rd=3, reg_we=1.
- lw, imm=0xFFFC, rd1=0x100 -> alu_b=0xFFFFFFFC, alu_op=010, mem_rd=1, wb_rd=rt.
- Forwarding, rs_idx=4:
  - exmem_we=1, exmem_rd=4, exmem_z=0xAA, memwb also targeting 4 with 0xBB -> alu_a=0xAA.
  - With rs_idx=0 and both sources targeting 0 -> alu_a=rd1.
- Stall: out_ready=0 for 3 cycles with new in_valid -> in_ready=0, outputs unchanged. Then out_ready=1 -> next instruction captured, no bubble.
- flush asserted while holding and in_valid=1 -> next cycle out_valid=0, new instruction not captured.
- opcode 0x3F -> illegal=1, reg_we=0, mem_wr=0.
